pipelined_add_sub: RTL and testbench



---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_slice.sv | 38 +++
 rtl/full_adder.sv | 20 ++
 rtl/pipelined_add_sub.sv | 154 +++++++++++++++
 tb/tb_pipelined_add_sub.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined adder/subtractor family.
//   MODE_ADD / MODE_SUB : encoding of the 'sub' mode input.
//   cfg_is_legal()      : checks that WIDTH splits evenly into STAGES slices.
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // True when the operand width divides into at least one equal slice.
    // The && short-circuits, so the modulo is never evaluated with stages = 0.
    function automatic bit cfg_is_legal(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
// Combinational W-bit ripple-carry adder built from full_adder cells.
//   a, b    : W-bit slice operands (b already conditioned for subtraction)
//   cin     : carry into bit 0
//   sum     : W-bit slice result
//   cout    : carry out of the slice MSB
//   msb_cin : carry into the slice MSB, used for signed-overflow detection
// -----------------------------------------------------------------------------
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         msb_cin
);

    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign cout    = carry[W];
    assign msb_cin = carry[W-1];

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_add_sub.sv
// -----------------------------------------------------------------------------
// pipelined_add_sub
// WIDTH-bit adder/subtractor split into STAGES equal slices, one slice per
// pipeline stage, with a valid/ready handshake on both sides.
//   clk, rst  : clock and synchronous active-high reset
//   in_valid  : operands a, b and mode sub are valid this cycle
//   in_ready  : block accepts operands this cycle (= pipeline advance)
//   a, b      : WIDTH-bit operands
//   sub       : 0 = a + b, 1 = a - b
//   out_valid : s, c_out, ovf hold a result
//   out_ready : consumer takes the result this cycle
//   s         : result modulo 2^WIDTH
//   c_out     : raw carry out of the MSB (in subtract mode 1 = no borrow)
//   ovf       : two's-complement signed overflow
//
// Stage k register layout:
//   word_q[k] : slices 0..k hold finished result bits, slices above hold the
//               still-unprocessed bits of operand A (skew and deskew in one word)
//   bop_q[k]  : operand B as accepted; only slices above k are still needed
//   c_q[k]    : carry out of slice k, feeding slice k+1 next cycle
//   sub_q[k]  : mode bit travelling with the operation
//   v_q[k]    : stage holds a live operation
// A single global advance (no consumer stall) moves every stage at once, so
// an accepted operation appears at the output exactly STAGES cycles later.
// -----------------------------------------------------------------------------
module pipelined_add_sub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int W    = (STAGES > 0) ? WIDTH / STAGES : 1;
    localparam int LAST = STAGES - 1;

    if (!cfg_is_legal(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_add_sub: WIDTH must be a positive multiple of STAGES");
    end

    // Pipeline state
    logic                             adv;
    logic [STAGES-1:0]                v_q;
    logic [STAGES-1:0]                sub_q;
    logic [STAGES-1:0]                c_q;
    logic [STAGES-1:0][WIDTH-1:0]     word_q;
    logic [STAGES-1:0][WIDTH-1:0]     bop_q;
    logic                             ovf_q;

    // Per-stage inputs (from the previous stage, or the ports for stage 0)
    logic [STAGES-1:0]                v_in;
    logic [STAGES-1:0]                sub_in;
    logic [STAGES-1:0]                c_in;
    logic [STAGES-1:0][WIDTH-1:0]     word_in;
    logic [STAGES-1:0][WIDTH-1:0]     bop_in;

    // Per-stage combinational results
    logic [STAGES-1:0][WIDTH-1:0]     word_d;
    logic [STAGES-1:0][W-1:0]         sum;
    logic [STAGES-1:0]                cout;
    logic [STAGES-1:0]                msb_cin;

    // The whole pipeline moves unless a finished result is waiting unconsumed.
    assign adv      = !v_q[LAST] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] b_slice;

        if (k == 0) begin : g_head
            // Carry-in of the first slice is the mode bit: a - b = a + ~b + 1.
            assign v_in[k]    = in_valid;
            assign sub_in[k]  = sub;
            assign c_in[k]    = (sub == MODE_SUB);
            assign word_in[k] = a;
            assign bop_in[k]  = b;
        end else begin : g_body
            assign v_in[k]    = v_q[k-1];
            assign sub_in[k]  = sub_q[k-1];
            assign c_in[k]    = c_q[k-1];
            assign word_in[k] = word_q[k-1];
            assign bop_in[k]  = bop_q[k-1];
        end

        // Each stage conditions its own B slice with the mode bit that
        // travels alongside the operation, so mixed add/sub streams work.
        assign b_slice = bop_in[k][k*W +: W] ^ {W{sub_in[k] == MODE_SUB}};

        adder_slice #(
            .W (W)
        ) u_slice (
            .a       (word_in[k][k*W +: W]),
            .b       (b_slice),
            .cin     (c_in[k]),
            .sum     (sum[k]),
            .cout    (cout[k]),
            .msb_cin (msb_cin[k])
        );

        // Replace slice k (operand A) with its sum; all other slices pass.
        for (genvar j = 0; j < STAGES; j++) begin : g_merge
            if (j == k) begin : g_sum
                assign word_d[k][j*W +: W] = sum[k];
            end else begin : g_pass
                assign word_d[k][j*W +: W] = word_in[k][j*W +: W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value; blocking here would collapse
    // the pipeline into a single cycle.
    // NOTE: only the valid bits and the output-facing registers are reset;
    // the remaining data registers are don't-care while their valid is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q          <= '0;
            word_q[LAST] <= '0;
            c_q[LAST]    <= 1'b0;
            ovf_q        <= 1'b0;
        end else if (adv) begin
            v_q    <= v_in;
            sub_q  <= sub_in;
            c_q    <= cout;
            word_q <= word_d;
            bop_q  <= bop_in;
            // Signed overflow: carry into the MSB differs from carry out.
            ovf_q  <= msb_cin[LAST] ^ cout[LAST];
        end
    end

    assign out_valid = v_q[LAST];
    assign s         = word_q[LAST];
    assign c_out     = c_q[LAST];
    assign ovf       = ovf_q;

    // The last stage's B copy and mode bit, and the intermediate MSB carries,
    // have no consumer; fold them into one sink so they are not left dangling.
    logic unused_tail;
    assign unused_tail = ^{bop_q[LAST], sub_q[LAST], msb_cin};

endmodule

// File: tb/tb_pipelined_add_sub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_add_sub
// Self-checking bench for pipelined_add_sub (WIDTH = 32, STAGES = 4).
// A monitor compares every presented result against a scoreboard filled
// from an arithmetic reference model at acceptance time.
// -----------------------------------------------------------------------------
module tb_pipelined_add_sub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam longint SMAX = (longint'(1) <<< (WIDTH - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } res_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;
    res_t sb[$];

    pipelined_add_sub #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: plain unsigned/signed arithmetic on wide integers.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic op);
        res_t   r;
        longint ux = longint'({32'd0, x});
        longint uy = longint'({32'd0, y});
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint sr;
        if (op) begin
            r.s = x - y;
            r.c = (ux >= uy);
            sr  = sx - sy;
        end else begin
            r.s = x + y;
            r.c = ((ux + uy) >> WIDTH) != 0;
            sr  = sx + sy;
        end
        r.v = (sr > SMAX) || (sr < SMIN);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no response within cycle budget (t=%0t)", name, $time);
    endtask

    // Monitor: samples just before each rising edge, compares any presented
    // result with the scoreboard head, and records accepted operations.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("stale_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("sb_s",     64'(s),     64'(sb[0].s));
                    check("sb_c_out", 64'(c_out), 64'(sb[0].c));
                    check("sb_ovf",   64'(ovf),   64'(sb[0].v));
                    if (out_ready) begin
                        sb.delete(0);
                        n_pops++;
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, sub));
        end
    end

    // Present one operation (caller is at a falling edge) and return at the
    // falling edge after it has been accepted.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic op);
        int waited = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sub      = op;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) timeout_fail("send_wait");
        @(negedge clk);
    endtask

    // Single operation with an unstalled consumer; checks latency and values.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        sub       = v.sub;
        out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d_in_ready", idx), 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            timeout_fail($sformatf("vec%0d_wait", idx));
        end else begin
            check($sformatf("vec%0d_latency", idx), 64'(lat),   64'(STAGES));
            check($sformatf("vec%0d_s", idx),       64'(s),     64'(v.s));
            check($sformatf("vec%0d_c_out", idx),   64'(c_out), 64'(v.c));
            check($sformatf("vec%0d_ovf", idx),     64'(ovf),   64'(v.v));
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [8];
        int   first, last, cnt, pops0, c;

        vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, sub: 1'b0, s: 32'h0000_0000, c: 1'b1, v: 1'b0};
        vecs[1] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, sub: 1'b0, s: 32'h8000_0000, c: 1'b0, v: 1'b1};
        vecs[2] = '{a: 32'h0000_0005, b: 32'h0000_0007, sub: 1'b1, s: 32'hFFFF_FFFE, c: 1'b0, v: 1'b0};
        vecs[3] = '{a: 32'h8000_0000, b: 32'h0000_0001, sub: 1'b1, s: 32'h7FFF_FFFF, c: 1'b1, v: 1'b1};
        vecs[4] = '{a: 32'h0000_0000, b: 32'h0000_0000, sub: 1'b1, s: 32'h0000_0000, c: 1'b1, v: 1'b0};
        vecs[5] = '{a: 32'h0000_FFFF, b: 32'h0000_0001, sub: 1'b0, s: 32'h0001_0000, c: 1'b0, v: 1'b0};
        vecs[6] = '{a: 32'h8000_0000, b: 32'h8000_0000, sub: 1'b0, s: 32'h0000_0000, c: 1'b1, v: 1'b1};
        vecs[7] = '{a: 32'h1234_5678, b: 32'h1234_5678, sub: 1'b1, s: 32'h0000_0000, c: 1'b1, v: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_s",        64'(s),        64'd0);
        check("rst_c_out",    64'(c_out),    64'd0);
        check("rst_ovf",      64'(ovf),      64'd0);
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Six back-to-back operations, alternating add and subtract
        out_ready = 1'b1;
        first = -1;
        last  = -1;
        cnt   = 0;
        pops0 = n_pops;
        fork
            begin
                for (int i = 0; i < 6; i++) send($urandom, $urandom, logic'(i % 2));
                in_valid = 1'b0;
            end
            begin
                for (int k = 1; k <= 16; k++) begin
                    @(negedge clk);
                    #2;
                    if (out_valid) begin
                        if (first < 0) first = k;
                        last = k;
                        cnt++;
                    end
                end
            end
        join
        check("b2b_first_latency", 64'(first),            64'(STAGES));
        check("b2b_count",         64'(cnt),              64'd6);
        check("b2b_contiguous",    64'(last - first + 1), 64'd6);
        check("b2b_pops",          64'(n_pops - pops0),   64'd6);

        // Fill the pipeline with the consumer stalled, then drain
        @(negedge clk);
        out_ready = 1'b0;
        pops0 = n_pops;
        for (int i = 0; i < 4; i++) send(rand_operand(), rand_operand(), logic'(i % 2));
        in_valid = 1'b1;
        a        = 32'h0000_0010;
        b        = 32'h0000_0020;
        sub      = 1'b1;
        #1;
        check("stall_in_ready_full", 64'(in_ready),  64'd0);
        check("stall_out_valid",     64'(out_valid), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("stall_hold_in_ready",  64'(in_ready),  64'd0);
            check("stall_hold_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        c = 0;
        while (sb.size() != 0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (sb.size() != 0) timeout_fail("stall_drain");
        check("stall_drain_pops",  64'(n_pops - pops0), 64'd5);
        check("stall_drain_empty", 64'(out_valid),      64'd0);

        // Reset with three operations in flight
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(rand_operand(), rand_operand(), logic'(i % 2));
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h0000_0003;
        b        = 32'h0000_0004;
        sub      = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_s",         64'(s),         64'd0);
        check("midrst_c_out",     64'(c_out),     64'd0);
        check("midrst_ovf",       64'(ovf),       64'd0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) cnt++;
        end
        check("midrst_no_stale", 64'(cnt), 64'd0);

        // Random traffic with random bubbles and consumer stalls
        @(negedge clk);
        cnt = 0;
        c   = 0;
        while (cnt < 10000 && c < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            a         = rand_operand();
            b         = rand_operand();
            sub       = logic'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (in_valid && in_ready) cnt++;
            @(negedge clk);
            c++;
        end
        if (cnt < 10000) timeout_fail("random_ops");
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while (sb.size() != 0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("random_drain", 64'(sb.size()), 64'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
